// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared types, select constants and the stall/bubble/issue resolver.
package hazard_scoreboard_pkg;
   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

   typedef struct packed {
      logic ext_stall;
      logic load_use;
      logic sb_hit;
      logic struct_hz;
      logic d_valid;
      logic d_is_md;
   } hazard_v2_input;

   typedef struct packed {
      logic stall;
      logic flush;
      logic md_issue;
   } hazard_v2_output;

   function automatic hazard_v2_output hazard_resolve(input hazard_v2_input h);
      hazard_v2_output o;
      o.stall    = h.ext_stall | h.load_use | h.sb_hit | h.struct_hz;
      o.flush    = o.stall & ~h.ext_stall;
      o.md_issue = h.d_valid & h.d_is_md & ~o.stall;
      return o;
   endfunction
endpackage

// File: rtl/hazard_scoreboard_md_tracker.sv
// md_tracker: MD unit sequencer; issue -> BUSY countdown -> one-cycle DONE, with scoreboard entry.
module md_tracker
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              md_issue,
   input  logic [REG_AW-1:0] d_rd,
   output logic              md_busy,
   output logic              pending,
   output logic [REG_AW-1:0] pend_rd,
   output logic              md_done,
   output logic [REG_AW-1:0] md_wb_rd
);
   md_state_t         r_state, w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_pend;
   logic [REG_AW-1:0] r_pend_rd;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_pend    <= 1'b0;
         r_pend_rd <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && md_issue) begin
            r_cnt     <= CNT_W'(MD_LAT - 2);
            r_pend_rd <= d_rd;
            r_pend    <= d_rd != '0;
         end else if (r_state == BUSY && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end else if (r_state == DONE) begin
            r_pend <= 1'b0;
         end
      end
   end

   always_comb begin
      w_next = r_state == IDLE ? (md_issue ? BUSY : IDLE) :
               r_state == BUSY ? (r_cnt == '0 ? DONE : BUSY) : IDLE;
   end

   assign md_busy  = r_state != IDLE;
   assign md_done  = r_state == DONE;
   assign pending  = r_pend;
   assign pend_rd  = r_pend_rd;
   assign md_wb_rd = md_done ? r_pend_rd : '0;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: XX/MX forwarding, load-use and MD scoreboard stalls for the 5-stage pipe.
// Optional perf counters enabled by HAZARD_PERF_EN; otherwise the perf ports read 0.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              d_valid,
   input  logic [REG_AW-1:0] d_rs,
   input  logic [REG_AW-1:0] d_rt,
   input  logic              d_use_rs,
   input  logic              d_use_rt,
   input  logic              d_is_md,
   input  logic [REG_AW-1:0] d_rd,
   input  logic [REG_AW-1:0] x_rd,
   input  logic              x_wr_en,
   input  logic              x_is_load,
   input  logic [REG_AW-1:0] m_rd,
   input  logic              m_wr_en,
   input  logic              ext_stall,
   output logic              fwd_xx_rs,
   output logic              fwd_xx_rt,
   output logic              fwd_mx_rs,
   output logic              fwd_mx_rt,
   output logic              stall_if,
   output logic              stall_d,
   output logic              flush_x,
   output logic              md_issue,
   output logic              md_busy,
   output logic              md_done,
   output logic [REG_AW-1:0] md_wb_rd,
   output logic [31:0]       perf_stall_cyc,
   output logic [31:0]       perf_fwd_cnt
);
   logic              w_x_fwd, w_m_fwd, w_xx_rs, w_xx_rt, w_mx_rs, w_mx_rt;
   logic              w_pending;
   logic [REG_AW-1:0] w_pend_rd;
   hazard_v2_input    w_hin;
   hazard_v2_output   w_hout;

   assign w_x_fwd = x_wr_en & ~x_is_load & (x_rd != '0);
   assign w_m_fwd = m_wr_en & (m_rd != '0);
   assign w_xx_rs = w_x_fwd & (x_rd == d_rs);
   assign w_xx_rt = w_x_fwd & (x_rd == d_rt);
   assign w_mx_rs = w_m_fwd & (m_rd == d_rs) & ~w_xx_rs;
   assign w_mx_rt = w_m_fwd & (m_rd == d_rt) & ~w_xx_rt;

   assign fwd_xx_rs = w_xx_rs ? ENABLE : DISABLE;
   assign fwd_xx_rt = w_xx_rt ? ENABLE : DISABLE;
   assign fwd_mx_rs = w_mx_rs ? ENABLE : DISABLE;
   assign fwd_mx_rt = w_mx_rt ? ENABLE : DISABLE;

   // Every hazard term uses only inputs and registered MD state, so issue cannot loop back into stall.
   assign w_hin.ext_stall = ext_stall;
   assign w_hin.load_use  = d_valid & x_wr_en & x_is_load & (x_rd != '0) &
                            ((d_use_rs & (x_rd == d_rs)) | (d_use_rt & (x_rd == d_rt)));
   assign w_hin.sb_hit    = d_valid & w_pending & (((w_pend_rd == d_rs) & d_use_rs) |
                            ((w_pend_rd == d_rt) & d_use_rt) | (w_pend_rd == d_rd));
   assign w_hin.struct_hz = d_valid & d_is_md & md_busy;
   assign w_hin.d_valid   = d_valid;
   assign w_hin.d_is_md   = d_is_md;
   assign w_hout          = hazard_resolve(w_hin);

   assign stall_d  = w_hout.stall;
   assign stall_if = w_hout.stall;
   assign flush_x  = w_hout.flush;
   assign md_issue = w_hout.md_issue & ~reset;

   md_tracker #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) u_md (
      .clk      (clk),
      .reset    (reset),
      .md_issue (md_issue),
      .d_rd     (d_rd),
      .md_busy  (md_busy),
      .pending  (w_pending),
      .pend_rd  (w_pend_rd),
      .md_done  (md_done),
      .md_wb_rd (md_wb_rd)
   );

`ifdef HAZARD_PERF_EN
   logic        w_any_fwd;
   logic [31:0] r_perf_stall, r_perf_fwd;
   assign w_any_fwd = w_xx_rs | w_xx_rt | w_mx_rs | w_mx_rt;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_stall <= '0;
         r_perf_fwd   <= '0;
      end else begin
         if (w_hout.stall && !(&r_perf_stall)) r_perf_stall <= r_perf_stall + 1'b1;
         if (w_any_fwd && !(&r_perf_fwd)) r_perf_fwd <= r_perf_fwd + 1'b1;
      end
   end
   assign perf_stall_cyc = r_perf_stall;
   assign perf_fwd_cnt   = r_perf_fwd;
`else
   assign perf_stall_cyc = '0;
   assign perf_fwd_cnt   = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed plan cases plus random traffic checked against a cycle-indexed model.
module tb_hazard_scoreboard;
   localparam int AW  = 5;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          reset, d_valid, d_use_rs, d_use_rt, d_is_md, x_wr_en, x_is_load, m_wr_en, ext_stall;
   logic [AW-1:0] d_rs, d_rt, d_rd, x_rd, m_rd;
   logic          fwd_xx_rs, fwd_xx_rt, fwd_mx_rs, fwd_mx_rt, stall_if, stall_d, flush_x;
   logic          md_issue, md_busy, md_done;
   logic [AW-1:0] md_wb_rd;
   logic [31:0]   perf_stall_cyc, perf_fwd_cnt;

   int n_chk = 0;
   int n_err = 0;

   int          cyc = 0;
   bit          m_act = 0;
   int          m_iss = 0;
   logic [AW-1:0] m_rd_q = '0;
   longint      p_stall = 0, p_fwd = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.REG_AW(AW), .MD_LAT(LAT), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
      .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_is_md(d_is_md), .d_rd(d_rd),
      .x_rd(x_rd), .x_wr_en(x_wr_en), .x_is_load(x_is_load), .m_rd(m_rd), .m_wr_en(m_wr_en),
      .ext_stall(ext_stall), .fwd_xx_rs(fwd_xx_rs), .fwd_xx_rt(fwd_xx_rt),
      .fwd_mx_rs(fwd_mx_rs), .fwd_mx_rt(fwd_mx_rt), .stall_if(stall_if), .stall_d(stall_d),
      .flush_x(flush_x), .md_issue(md_issue), .md_busy(md_busy), .md_done(md_done),
      .md_wb_rd(md_wb_rd), .perf_stall_cyc(perf_stall_cyc), .perf_fwd_cnt(perf_fwd_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic idle();
      d_valid = 0; d_use_rs = 0; d_use_rt = 0; d_is_md = 0; x_wr_en = 0; x_is_load = 0;
      m_wr_en = 0; ext_stall = 0; reset = 0;
      d_rs = '0; d_rt = '0; d_rd = '0; x_rd = '0; m_rd = '0;
   endtask

   // Model: an MD op issued at cycle t occupies cycles t+1..t+LAT and completes at t+LAT.
   task automatic run_cycle();
      bit busy, done, pend, xx_rs, xx_rt, mx_rs, mx_rt, lu, sb, st, stall, iss;
      #3;
      busy  = m_act && cyc > m_iss && cyc <= m_iss + LAT;
      done  = m_act && cyc == m_iss + LAT;
      pend  = busy && m_rd_q != 0;
      xx_rs = x_wr_en && !x_is_load && x_rd != 0 && x_rd == d_rs;
      xx_rt = x_wr_en && !x_is_load && x_rd != 0 && x_rd == d_rt;
      mx_rs = m_wr_en && m_rd != 0 && m_rd == d_rs && !xx_rs;
      mx_rt = m_wr_en && m_rd != 0 && m_rd == d_rt && !xx_rt;
      lu    = d_valid && x_wr_en && x_is_load && x_rd != 0 &&
              ((d_use_rs && x_rd == d_rs) || (d_use_rt && x_rd == d_rt));
      sb    = d_valid && pend && ((m_rd_q == d_rs && d_use_rs) || (m_rd_q == d_rt && d_use_rt) || m_rd_q == d_rd);
      st    = d_valid && d_is_md && busy;
      stall = ext_stall || lu || sb || st;
      iss   = d_valid && d_is_md && !stall;
      if (!reset) begin
         check("fwd", {fwd_xx_rs, fwd_xx_rt, fwd_mx_rs, fwd_mx_rt}, {xx_rs, xx_rt, mx_rs, mx_rt});
         check("stall", {stall_if, stall_d, flush_x}, {stall, stall, stall && !ext_stall});
         check("md", {md_issue, md_busy, md_done}, {iss, busy, done});
         check("wb_rd", md_wb_rd, done ? m_rd_q : '0);
`ifdef HAZARD_PERF_EN
         check("perf_stall", perf_stall_cyc, p_stall >= 64'hFFFFFFFF ? 32'hFFFFFFFF : 32'(p_stall));
         check("perf_fwd", perf_fwd_cnt, p_fwd >= 64'hFFFFFFFF ? 32'hFFFFFFFF : 32'(p_fwd));
`else
         check("perf_off", {perf_stall_cyc, perf_fwd_cnt} == 64'd0, 1);
`endif
      end
      if (reset) begin
         m_act = 0; p_stall = 0; p_fwd = 0;
      end else begin
         if (stall) p_stall++;
         if (xx_rs || xx_rt || mx_rs || mx_rt) p_fwd++;
         if (iss) begin m_act = 1; m_iss = cyc; m_rd_q = d_rd; end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      reset = 1;
      @(posedge clk); #1;
      run_cycle();
      idle(); #1;
      check("rst_busy", md_busy, 0);
      check("rst_done", md_done, 0);
      // Forwarding priority
      d_valid = 1; x_rd = 3; x_wr_en = 1; d_rs = 3; d_use_rs = 1; m_rd = 3; m_wr_en = 1;
      #1 check("t1_xx", fwd_xx_rs, 1); check("t1_mx", fwd_mx_rs, 0); check("t1_st", stall_d, 0);
      run_cycle();
      // Load-use, then x_rd=0
      idle(); d_valid = 1; x_wr_en = 1; x_is_load = 1; x_rd = 7; d_rt = 7; d_use_rt = 1;
      #1 check("t2_lu", {stall_d, stall_if, flush_x}, 3'b111);
      run_cycle();
      x_rd = 0;
      #1 check("t2_r0", stall_d, 0);
      run_cycle();
      // MD RAW dependency
      idle(); d_valid = 1; d_is_md = 1; d_rd = 9;
      #1 check("t3_iss", md_issue, 1);
      run_cycle();
      for (int k = 1; k <= 5; k++) begin
         idle(); d_valid = 1; d_rs = 9; d_use_rs = 1; d_rd = 2;
         #1 check("t3_stall", stall_d, k <= 4);
         if (k == 4) begin check("t3_done", md_done, 1); check("t3_wbrd", md_wb_rd, 9); end
         run_cycle();
      end
      // Structural hazard on second MD op
      idle(); d_valid = 1; d_is_md = 1; d_rd = 5;
      run_cycle();
      for (int k = 1; k <= 5; k++) begin
         idle(); d_valid = 1; d_is_md = 1; d_rd = 6;
         #1 check("t4_iss", md_issue, k == 5);
         run_cycle();
      end
      idle();
      for (int k = 0; k < 5; k++) run_cycle();
      // Reset mid-operation
      d_valid = 1; d_is_md = 1; d_rd = 9;
      run_cycle();
      idle(); run_cycle();
      reset = 1; run_cycle();
      idle(); d_valid = 1; d_rs = 9; d_use_rs = 1;
      #1 check("t5_busy", md_busy, 0); check("t5_stall", stall_d, 0);
      run_cycle();
      // Perf: 3 stall cycles + 2 forwarding cycles
      idle(); reset = 1; run_cycle();
      for (int k = 0; k < 3; k++) begin
         idle(); d_valid = 1; x_wr_en = 1; x_is_load = 1; x_rd = 7; d_rt = 7; d_use_rt = 1;
         run_cycle();
      end
      for (int k = 0; k < 2; k++) begin
         idle(); x_wr_en = 1; x_rd = 3; d_rs = 3;
         run_cycle();
      end
      idle();
      #1;
`ifdef HAZARD_PERF_EN
      check("t6_stall", perf_stall_cyc, 3); check("t6_fwd", perf_fwd_cnt, 2);
`else
      check("t6_stall", perf_stall_cyc, 0); check("t6_fwd", perf_fwd_cnt, 0);
`endif
      run_cycle();
      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         reset     = $urandom_range(0, 59) == 0;
         d_valid   = $urandom_range(0, 5) != 0;
         d_is_md   = $urandom_range(0, 3) == 0;
         d_use_rs  = $urandom_range(0, 1) == 1;
         d_use_rt  = $urandom_range(0, 1) == 1;
         x_wr_en   = $urandom_range(0, 2) != 0;
         x_is_load = $urandom_range(0, 3) == 0;
         m_wr_en   = $urandom_range(0, 2) != 0;
         ext_stall = $urandom_range(0, 7) == 0;
         d_rs = AW'($urandom_range(0, 3)); d_rt = AW'($urandom_range(0, 3));
         d_rd = AW'($urandom_range(0, 3)); x_rd = AW'($urandom_range(0, 3));
         m_rd = AW'($urandom_range(0, 3));
         run_cycle();
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
